vend_credit_bcd: RTL and testbench

- Parametrised BCD credit accumulator for the vending machine.
- Accepts coin-insert pulses of three configurable denominations, purchase requests at a configurable price, and refund requests.
- Arithmetic is digit-serial BCD, with full carry/borrow across any number of digits, overflow rejection, insufficient-credit denial and change output.
- Sits between the key-flag debouncer and the seven-segment display interface; drives the display word Number_Sig.

---
 rtl/vend_credit_bcd.sv | 207 ++++++++++++++++++++
 tb/tb_vend_credit_bcd.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_credit_bcd.sv
// vend_credit_bcd -- BCD credit accumulator for the vending machine.
//
// Coin inserts add a fixed BCD denomination, a vend subtracts the price and a
// refund returns the whole credit as change. Add/subtract run one BCD digit
// per clock (LSB first) into a scratch register. The committed credit only
// changes on the COMMIT edge, and only if the final carry/borrow is clear.
//
// Ports:
//   CLK, RSTn          clock (rising edge), asynchronous active-low reset
//   coin_i[2:0]        one-cycle coin insert flags, bit n selects COINn_BCD
//   vend_req           one-cycle purchase request
//   refund_req         one-cycle change-return request
//   busy               high while an add/sub is in flight
//   credit_bcd         committed credit
//   Number_Sig         display snapshot, refreshed at commit or refund
//   vend_ok/vend_deny  purchase result pulses
//   coin_reject        coin would overflow DIGITS, credit unchanged
//   change_valid       qualifies change_bcd (which holds until next refund)
//   evt_drop           one or more request bits were discarded
module vend_credit_bcd #(
  parameter int                DIGITS    = 6,
  parameter logic [4*DIGITS-1:0] COIN0_BCD = 'h50,
  parameter logic [4*DIGITS-1:0] COIN1_BCD = 'h100,
  parameter logic [4*DIGITS-1:0] COIN2_BCD = 'h500,
  parameter logic [4*DIGITS-1:0] PRICE_BCD = 'h300
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic [2:0]          coin_i,
  input  logic                vend_req,
  input  logic                refund_req,
  output logic                busy,
  output logic [4*DIGITS-1:0] credit_bcd,
  output logic [4*DIGITS-1:0] Number_Sig,
  output logic                vend_ok,
  output logic                vend_deny,
  output logic                coin_reject,
  output logic                change_valid,
  output logic [4*DIGITS-1:0] change_bcd,
  output logic                evt_drop
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS);
  localparam logic [CW-1:0] LAST_DIG = CW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, CALC, COMMIT} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  a_sh;       // credit copy, shifted right one digit per CALC edge
  logic [W-1:0]  b_sh;       // operand, shifted alongside a_sh
  logic [W-1:0]  scratch;    // result digits shift in from the top
  logic          op_sub;
  logic          carry;      // carry for add, borrow for sub
  logic [CW-1:0] dig_idx;

  logic [4:0]    req_vec;
  logic          multi_req;
  logic          accept_refund;
  logic          accept_op;
  logic          op_sub_nxt;
  logic [W-1:0]  operand_nxt;
  logic          drop_nxt;
  logic [4:0]    dig_res;    // {carry_out, digit}

  // One BCD digit of a + b + c; returns {carry_out, digit}.
  function automatic logic [4:0] bcd_add_digit(input logic [3:0] a,
                                               input logic [3:0] b,
                                               input logic       c);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b} + {4'b0000, c};
    if (s > 5'd9) return {1'b1, 4'(s - 5'd10)};
    return {1'b0, s[3:0]};
  endfunction

  // One BCD digit of a - b - c; returns {borrow_out, digit}.
  function automatic logic [4:0] bcd_sub_digit(input logic [3:0] a,
                                               input logic [3:0] b,
                                               input logic       c);
    logic signed [5:0] d;
    d = $signed({2'b00, a}) - $signed({2'b00, b}) - $signed({5'b00000, c});
    if (d < 0) begin
      d = d + 6'sd10;
      return {1'b1, d[3:0]};
    end
    return {1'b0, d[3:0]};
  endfunction

  assign req_vec   = {refund_req, vend_req, coin_i};
  // More than one bit set: clearing the lowest set bit leaves something.
  assign multi_req = (req_vec & (req_vec - 5'd1)) != 5'd0;

  assign dig_res = op_sub ? bcd_sub_digit(a_sh[3:0], b_sh[3:0], carry)
                          : bcd_add_digit(a_sh[3:0], b_sh[3:0], carry);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    accept_refund = 1'b0;
    accept_op     = 1'b0;
    op_sub_nxt    = 1'b0;
    operand_nxt   = '0;
    drop_nxt      = 1'b0;
    case (state)
      IDLE: begin
        drop_nxt = multi_req;
        if (refund_req) begin
          accept_refund = 1'b1;
        end else if (vend_req) begin
          accept_op   = 1'b1;
          op_sub_nxt  = 1'b1;
          operand_nxt = PRICE_BCD;
        end else if (coin_i[2]) begin
          accept_op   = 1'b1;
          operand_nxt = COIN2_BCD;
        end else if (coin_i[1]) begin
          accept_op   = 1'b1;
          operand_nxt = COIN1_BCD;
        end else if (coin_i[0]) begin
          accept_op   = 1'b1;
          operand_nxt = COIN0_BCD;
        end
        if (accept_op) state_nxt = CALC;
      end
      CALC: begin
        drop_nxt = |req_vec;
        if (dig_idx == LAST_DIG) state_nxt = COMMIT;
      end
      COMMIT: begin
        drop_nxt  = |req_vec;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      busy         <= 1'b0;
      credit_bcd   <= '0;
      Number_Sig   <= '0;
      vend_ok      <= 1'b0;
      vend_deny    <= 1'b0;
      coin_reject  <= 1'b0;
      change_valid <= 1'b0;
      change_bcd   <= '0;
      evt_drop     <= 1'b0;
      a_sh         <= '0;
      b_sh         <= '0;
      scratch      <= '0;
      op_sub       <= 1'b0;
      carry        <= 1'b0;
      dig_idx      <= '0;
    end else begin
      vend_ok      <= 1'b0;
      vend_deny    <= 1'b0;
      coin_reject  <= 1'b0;
      change_valid <= 1'b0;
      evt_drop     <= drop_nxt;
      case (state)
        // Accept: refund completes here, coin/vend latch their operands
        IDLE: begin
          if (accept_refund) begin
            change_bcd   <= credit_bcd;
            change_valid <= 1'b1;
            credit_bcd   <= '0;
            Number_Sig   <= '0;
          end else if (accept_op) begin
            a_sh    <= credit_bcd;
            b_sh    <= operand_nxt;
            op_sub  <= op_sub_nxt;
            carry   <= 1'b0;
            dig_idx <= '0;
            busy    <= 1'b1;
          end
        end
        // Digit-serial add/sub, LSB first
        CALC: begin
          a_sh    <= a_sh >> 4;
          b_sh    <= b_sh >> 4;
          scratch <= {dig_res[3:0], scratch[W-1:4]};
          carry   <= dig_res[4];
          dig_idx <= dig_idx + CW'(1);
        end
        // Commit: a final carry means overflow, a final borrow means too little credit
        COMMIT: begin
          busy <= 1'b0;
          if (carry) begin
            Number_Sig  <= credit_bcd;
            vend_deny   <= op_sub;
            coin_reject <= !op_sub;
          end else begin
            credit_bcd <= scratch;
            Number_Sig <= scratch;
            vend_ok    <= op_sub;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_credit_bcd.sv
module tb_vend_credit_bcd;
  localparam int DIGITS = 6;
  localparam int W      = 4 * DIGITS;
  localparam int D3     = 3;
  localparam int W3     = 12;

  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;

  logic [2:0]   coin_i = '0;
  logic         vend_req = 1'b0, refund_req = 1'b0;
  logic         busy, vend_ok, vend_deny, coin_reject, change_valid, evt_drop;
  logic [W-1:0] credit_bcd, Number_Sig, change_bcd;

  logic [2:0]    coin3_i = '0;
  logic          vend3_req = 1'b0, refund3_req = 1'b0;
  logic          busy3, vend_ok3, vend_deny3, coin_reject3, change_valid3, evt_drop3;
  logic [W3-1:0] credit3, number3, change3;

  vend_credit_bcd #(.DIGITS(DIGITS)) dut (
    .CLK(CLK), .RSTn(RSTn), .coin_i(coin_i), .vend_req(vend_req),
    .refund_req(refund_req), .busy(busy), .credit_bcd(credit_bcd),
    .Number_Sig(Number_Sig), .vend_ok(vend_ok), .vend_deny(vend_deny),
    .coin_reject(coin_reject), .change_valid(change_valid),
    .change_bcd(change_bcd), .evt_drop(evt_drop)
  );

  vend_credit_bcd #(.DIGITS(D3), .COIN0_BCD('h50), .COIN1_BCD('h90),
                    .COIN2_BCD('h900), .PRICE_BCD('h300)) dut3 (
    .CLK(CLK), .RSTn(RSTn), .coin_i(coin3_i), .vend_req(vend3_req),
    .refund_req(refund3_req), .busy(busy3), .credit_bcd(credit3),
    .Number_Sig(number3), .vend_ok(vend_ok3), .vend_deny(vend_deny3),
    .coin_reject(coin_reject3), .change_valid(change_valid3),
    .change_bcd(change3), .evt_drop(evt_drop3)
  );

  int checks = 0;
  int failures = 0;

  // Decimal fen -> BCD, the reference representation of an amount.
  function automatic logic [23:0] bcd(input int v);
    logic [23:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    RSTn = 1'b0;
    coin_i = '0; vend_req = 1'b0; refund_req = 1'b0;
    coin3_i = '0; vend3_req = 1'b0; refund3_req = 1'b0;
    tick();
    tick();
    RSTn = 1'b1;
  endtask

  // Present a request for one edge (the accept edge) and withdraw it.
  task automatic issue(input logic [2:0] c, input logic v, input logic r);
    coin_i = c; vend_req = v; refund_req = r;
    tick();
    coin_i = '0; vend_req = 1'b0; refund_req = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] c, input logic v);
    issue(c, v, 1'b0);
    repeat (DIGITS + 1) tick();
  endtask

  task automatic run_op3(input logic [2:0] c);
    coin3_i = c;
    tick();
    coin3_i = '0;
    repeat (D3 + 1) tick();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({busy, credit_bcd, Number_Sig, vend_ok, vend_deny, coin_reject,
         change_valid, change_bcd, evt_drop} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b credit=%h num=%h chg=%h pulses=%b%b%b%b%b req=all zero",
               busy, credit_bcd, Number_Sig, change_bcd, vend_ok, vend_deny,
               coin_reject, change_valid, evt_drop);
    end
    checks++;
    if ({busy3, credit3, number3, change3} !== '0) begin
      failures++;
      $display("FAIL reset_outputs3 got busy=%b credit=%h req=0", busy3, credit3);
    end
  endtask

  task automatic test_coin_accum();
    int exp_v;
    exp_v = 0;
    for (int n = 0; n < 3; n++) begin
      issue(3'b001, 1'b0, 1'b0);
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL accum_busy_start got=%b req=1", busy);
      end
      repeat (DIGITS) tick();
      checks++;
      if (busy !== 1'b1 || credit_bcd !== bcd(exp_v)) begin
        failures++;
        $display("FAIL accum_pre_commit got busy=%b credit=%h req busy=1 credit=%h",
                 busy, credit_bcd, bcd(exp_v));
      end
      tick();
      exp_v += 50;
      checks++;
      if (busy !== 1'b0 || credit_bcd !== bcd(exp_v) || Number_Sig !== bcd(exp_v)) begin
        failures++;
        $display("FAIL accum_commit got busy=%b credit=%h num=%h req=%h",
                 busy, credit_bcd, Number_Sig, bcd(exp_v));
      end
    end
    checks++;
    if (credit_bcd !== 24'h150) begin
      failures++;
      $display("FAIL accum_total got=%h req=000150", credit_bcd);
    end
  endtask

  task automatic test_carry_ripple();
    run_op(3'b100, 1'b0);
    repeat (3) run_op(3'b010, 1'b0);
    checks++;
    if (credit_bcd !== 24'h950) begin
      failures++;
      $display("FAIL ripple_setup got=%h req=000950", credit_bcd);
    end
    run_op(3'b001, 1'b0);
    checks++;
    if (credit_bcd !== 24'h1000 || Number_Sig !== 24'h1000 ||
        {vend_ok, vend_deny, coin_reject, change_valid} !== 4'b0000) begin
      failures++;
      $display("FAIL ripple_result got credit=%h num=%h pulses=%b%b%b%b req=001000 none",
               credit_bcd, Number_Sig, vend_ok, vend_deny, coin_reject, change_valid);
    end
  endtask

  task automatic test_vend();
    apply_reset();
    run_op(3'b010, 1'b0);
    run_op(3'b010, 1'b0);
    run_op(3'b000, 1'b1);
    checks++;
    if (vend_deny !== 1'b1 || vend_ok !== 1'b0 || credit_bcd !== 24'h200) begin
      failures++;
      $display("FAIL vend_deny got deny=%b ok=%b credit=%h req deny=1 ok=0 credit=000200",
               vend_deny, vend_ok, credit_bcd);
    end
    tick();
    checks++;
    if (vend_deny !== 1'b0) begin
      failures++;
      $display("FAIL vend_deny_width got=%b req=0", vend_deny);
    end
    run_op(3'b100, 1'b0);
    checks++;
    if (credit_bcd !== 24'h700) begin
      failures++;
      $display("FAIL vend_topup got=%h req=000700", credit_bcd);
    end
    run_op(3'b000, 1'b1);
    checks++;
    if (vend_ok !== 1'b1 || vend_deny !== 1'b0 || credit_bcd !== 24'h400 ||
        Number_Sig !== 24'h400) begin
      failures++;
      $display("FAIL vend_ok got ok=%b deny=%b credit=%h num=%h req ok=1 credit=000400",
               vend_ok, vend_deny, credit_bcd, Number_Sig);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    run_op3(3'b100);
    run_op3(3'b010);
    checks++;
    if (credit3 !== 12'h990) begin
      failures++;
      $display("FAIL ovf_setup got=%h req=990", credit3);
    end
    run_op3(3'b001);
    checks++;
    if (coin_reject3 !== 1'b1 || credit3 !== 12'h990 || number3 !== 12'h990 ||
        vend_ok3 !== 1'b0 || vend_deny3 !== 1'b0) begin
      failures++;
      $display("FAIL ovf_reject got rej=%b credit=%h num=%h req rej=1 credit=990",
               coin_reject3, credit3, number3);
    end
    tick();
    checks++;
    if (coin_reject3 !== 1'b0) begin
      failures++;
      $display("FAIL ovf_reject_width got=%b req=0", coin_reject3);
    end
  endtask

  task automatic test_priority_drop();
    apply_reset();
    run_op(3'b100, 1'b0);
    issue(3'b100, 1'b1, 1'b0);
    checks++;
    if (evt_drop !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL prio_drop got drop=%b busy=%b req drop=1 busy=1", evt_drop, busy);
    end
    repeat (DIGITS + 1) tick();
    checks++;
    if (vend_ok !== 1'b1 || credit_bcd !== 24'h200 || evt_drop !== 1'b0) begin
      failures++;
      $display("FAIL prio_result got ok=%b credit=%h drop=%b req ok=1 credit=000200 drop=0",
               vend_ok, credit_bcd, evt_drop);
    end
  endtask

  task automatic test_busy_drop();
    issue(3'b010, 1'b0, 1'b0);
    tick();
    tick();
    coin_i = 3'b001;
    tick();
    coin_i = '0;
    checks++;
    if (evt_drop !== 1'b1) begin
      failures++;
      $display("FAIL busy_drop got=%b req=1", evt_drop);
    end
    tick();
    checks++;
    if (evt_drop !== 1'b0) begin
      failures++;
      $display("FAIL busy_drop_width got=%b req=0", evt_drop);
    end
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || credit_bcd !== 24'h300) begin
      failures++;
      $display("FAIL busy_drop_credit got busy=%b credit=%h req busy=0 credit=000300",
               busy, credit_bcd);
    end
  endtask

  task automatic test_refund();
    apply_reset();
    repeat (3) run_op(3'b010, 1'b0);
    run_op(3'b001, 1'b0);
    issue(3'b000, 1'b0, 1'b1);
    checks++;
    if (change_valid !== 1'b1 || change_bcd !== 24'h350 || credit_bcd !== '0 ||
        Number_Sig !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL refund got cv=%b chg=%h credit=%h num=%h busy=%b req cv=1 chg=000350 credit=0",
               change_valid, change_bcd, credit_bcd, Number_Sig, busy);
    end
    tick();
    checks++;
    if (change_valid !== 1'b0 || change_bcd !== 24'h350) begin
      failures++;
      $display("FAIL refund_hold got cv=%b chg=%h req cv=0 chg=000350", change_valid, change_bcd);
    end
    issue(3'b000, 1'b0, 1'b1);
    checks++;
    if (change_valid !== 1'b1 || change_bcd !== '0) begin
      failures++;
      $display("FAIL refund_zero got cv=%b chg=%h req cv=1 chg=0", change_valid, change_bcd);
    end
  endtask

  task automatic test_reset_mid_calc();
    logic bad;
    run_op(3'b100, 1'b0);
    issue(3'b100, 1'b0, 1'b0);
    tick();
    tick();
    RSTn = 1'b0;
    #1;
    checks++;
    if ({busy, credit_bcd, Number_Sig, vend_ok, vend_deny, coin_reject,
         change_valid, change_bcd, evt_drop} !== '0) begin
      failures++;
      $display("FAIL midcalc_reset got busy=%b credit=%h num=%h chg=%h req=all zero",
               busy, credit_bcd, Number_Sig, change_bcd);
    end
    tick();
    RSTn = 1'b1;
    bad = 1'b0;
    repeat (DIGITS + 3) begin
      tick();
      if ({busy, vend_ok, vend_deny, coin_reject, change_valid} !== 5'b0 ||
          credit_bcd !== '0)
        bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("FAIL midcalc_after got=%b req=0 (late pulse or credit)", bad);
    end
  endtask

  // Random requests, including simultaneous ones and back-to-back accepts,
  // against a plain-integer model of the credit in fen.
  task automatic test_random();
    int m_credit, m_change, val, nreq;
    logic [2:0] c;
    logic v, r;
    logic [3:0] exp_p;
    apply_reset();
    m_credit = 0;
    m_change = 0;
    for (int it = 0; it < 60; it++) begin
      c = 3'($urandom_range(0, 7));
      v = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 7) == 0);
      if (!r && !v && c == 3'b000) c = 3'b001;
      nreq = $countones({r, v, c});
      exp_p = 4'b0000;
      if (r) begin
        m_change = m_credit;
        m_credit = 0;
        exp_p = 4'b0001;
      end else if (v) begin
        if (m_credit >= 300) begin m_credit -= 300; exp_p = 4'b1000; end
        else exp_p = 4'b0100;
      end else begin
        val = c[2] ? 500 : (c[1] ? 100 : 50);
        if (m_credit + val > 999999) exp_p = 4'b0010;
        else m_credit += val;
      end
      issue(c, v, r);
      checks++;
      if (evt_drop !== (nreq > 1) || busy !== !r) begin
        failures++;
        $display("FAIL rnd_accept it=%0d got drop=%b busy=%b req drop=%b busy=%b",
                 it, evt_drop, busy, nreq > 1, !r);
      end
      if (!r) repeat (DIGITS + 1) tick();
      checks++;
      if ({vend_ok, vend_deny, coin_reject, change_valid} !== exp_p ||
          credit_bcd !== bcd(m_credit) || Number_Sig !== bcd(m_credit) ||
          change_bcd !== bcd(m_change) || busy !== 1'b0) begin
        failures++;
        $display("FAIL rnd_result it=%0d got p=%b%b%b%b credit=%h num=%h chg=%h req p=%b credit=%h chg=%h",
                 it, vend_ok, vend_deny, coin_reject, change_valid, credit_bcd,
                 Number_Sig, change_bcd, exp_p, bcd(m_credit), bcd(m_change));
      end
    end
  endtask

  initial begin
    test_reset();
    test_coin_accum();
    test_carry_ripple();
    test_vend();
    test_overflow();
    test_priority_drop();
    test_busy_drop();
    test_refund();
    test_reset_mid_calc();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
